// File: rtl/block_aligner66.sv
// 66b block aligner: qualifies the seeker's header offset with a
// HUNT/VERIFY/LOCKED state machine, extracts aligned 66b blocks once locked,
// and drops lock when too many bad headers land inside one monitoring window.
//
// state  | meaning
// HUNT   | waiting for a valid offset (0..65) from the seeker
// VERIFY | counting consecutive identical offsets toward lock
// LOCKED | offset frozen; blocks emitted; header errors monitored
module block_aligner66 #(
  parameter int STABLE_CNT = 16,
  parameter int WIN_LEN    = 64,
  parameter int BAD_MAX    = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [193:0] gbox_buffer,
  input  logic [5:0]   gbox_cnt,
  input  logic         buffer_dv,
  input  logic [6:0]   block_offset,
  output logic [1:0]   blk_header_o,
  output logic [63:0]  blk_data_o,
  output logic         blk_dv_o,
  output logic         blk_hdr_err_o,
  output logic         locked_o,
  output logic [6:0]   lock_offset_o,
  output logic [7:0]   lock_loss_cnt_o
);

  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int BW = $clog2(BAD_MAX + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t          state, state_nx;
  logic [66:0]     w_cur, w_prev, w_in;
  logic            prev_valid;
  logic [133:0]    cat_in, cat;
  logic [1:0]      hdr_in;
  logic            hdr_in_bad;
  logic [65:0]     blk;
  logic [6:0]      cand, cand_nx;
  logic [SW-1:0]   stable, stable_nx;
  logic [WW-1:0]   win_cnt, win_nx, win_inc;
  logic [BW-1:0]   bad_cnt, bad_nx, bad_inc;
  logic [7:0]      loss_nx;
  logic            emit;
  logic            pend;
  logic [6:0]      pend_off;

  // The block judged on a dv is the one that becomes visible once this dv's
  // window is captured, so the header check looks ahead at {w_cur, w_in}.
  assign w_in       = gbox_buffer[193 - int'(gbox_cnt) -: 67];
  assign cat_in     = {w_cur, w_in};
  assign hdr_in     = cat_in[int'(cand) + 68 -: 2];
  assign hdr_in_bad = (hdr_in[1] == hdr_in[0]);
  assign win_inc    = win_cnt + 1'b1;
  assign bad_inc    = bad_cnt + BW'(hdr_in_bad);

  // Extraction reads the captured windows; pend_off keeps the offset of the
  // emitting dv in case the state machine leaves LOCKED meanwhile.
  assign cat = {w_prev, w_cur};
  assign blk = cat[int'(pend_off) + 68 -: 66];

  assign locked_o      = (state == LOCKED);
  assign lock_offset_o = cand;

  // Next-state logic: everything advances only on buffer_dv.
  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    stable_nx = stable;
    win_nx    = win_cnt;
    bad_nx    = bad_cnt;
    loss_nx   = lock_loss_cnt_o;
    emit      = 1'b0;
    if (buffer_dv) begin
      case (state)
        HUNT: begin
          if (block_offset <= 7'd65) begin
            state_nx  = VERIFY;
            cand_nx   = block_offset;
            stable_nx = SW'(1);
          end
        end
        VERIFY: begin
          if (block_offset > 7'd65) begin
            state_nx = HUNT;
          end else if (block_offset != cand) begin
            cand_nx   = block_offset;
            stable_nx = SW'(1);
          end else if (stable == SW'(STABLE_CNT - 1)) begin
            state_nx  = LOCKED;
            stable_nx = SW'(STABLE_CNT);
            win_nx    = '0;
            bad_nx    = '0;
          end else begin
            stable_nx = stable + 1'b1;
          end
        end
        LOCKED: begin
          emit = prev_valid;
          // Loss of lock takes priority over the window rollover.
          if (bad_inc == BW'(BAD_MAX)) begin
            state_nx = HUNT;
            win_nx   = '0;
            bad_nx   = '0;
            if (lock_loss_cnt_o != 8'hFF) loss_nx = lock_loss_cnt_o + 1'b1;
          end else if (win_inc == WW'(WIN_LEN)) begin
            win_nx = '0;
            bad_nx = '0;
          end else begin
            win_nx = win_inc;
            bad_nx = bad_inc;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // State machine and monitoring counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= HUNT;
      cand            <= '0;
      stable          <= '0;
      win_cnt         <= '0;
      bad_cnt         <= '0;
      lock_loss_cnt_o <= '0;
    end else begin
      state           <= state_nx;
      cand            <= cand_nx;
      stable          <= stable_nx;
      win_cnt         <= win_nx;
      bad_cnt         <= bad_nx;
      lock_loss_cnt_o <= loss_nx;
    end
  end

  // Window capture: two consecutive 67b views form the 134b search span.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_cur      <= '0;
      w_prev     <= '0;
      prev_valid <= 1'b0;
    end else if (buffer_dv) begin
      w_cur      <= w_in;
      w_prev     <= w_cur;
      prev_valid <= 1'b1;
    end
  end

  // Emission request, one cycle ahead of the output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend     <= 1'b0;
      pend_off <= '0;
    end else begin
      pend <= emit;
      if (emit) pend_off <= cand;
    end
  end

  // Block output register; header/data hold between strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_dv_o      <= 1'b0;
      blk_hdr_err_o <= 1'b0;
      blk_header_o  <= '0;
      blk_data_o    <= '0;
    end else begin
      blk_dv_o      <= pend;
      blk_hdr_err_o <= pend & (blk[65] == blk[64]);
      if (pend) begin
        blk_header_o <= blk[65:64];
        blk_data_o   <= blk[63:0];
      end
    end
  end

endmodule

// File: tb/tb_block_aligner66.sv
// Directed bench for block_aligner66: table of window/header vectors plus
// hand-written lock, re-hunt, window-boundary and async-reset sequences.
module tb_block_aligner66;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [193:0] gbox_buffer = '0;
  logic [5:0]   gbox_cnt = '0;
  logic         buffer_dv = 1'b0;
  logic [6:0]   block_offset = '0;
  logic [1:0]   blk_header_o;
  logic [63:0]  blk_data_o;
  logic         blk_dv_o;
  logic         blk_hdr_err_o;
  logic         locked_o;
  logic [6:0]   lock_offset_o;
  logic [7:0]   lock_loss_cnt_o;

  block_aligner66 dut (
    .clk_i(clk_i), .rst_i(rst_i), .gbox_buffer(gbox_buffer), .gbox_cnt(gbox_cnt),
    .buffer_dv(buffer_dv), .block_offset(block_offset),
    .blk_header_o(blk_header_o), .blk_data_o(blk_data_o), .blk_dv_o(blk_dv_o),
    .blk_hdr_err_o(blk_hdr_err_o), .locked_o(locked_o), .lock_offset_o(lock_offset_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  typedef struct packed {
    logic [5:0] cnt;
    logic [1:0] hdr;
    logic       err;
  } vec_t;
  vec_t tbl[8];

  logic [66:0] prev_chunk;
  logic [1:0]  prev_hdr;
  logic        prev_err;
  int          cur_off;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic is_bad(input logic [1:0] h);
    return (h == 2'b00) || (h == 2'b11);
  endfunction

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [66:0] mk_chunk(input logic [1:0] hdr, input int off);
    logic [95:0] r;
    logic [66:0] c;
    r = {$urandom, $urandom, $urandom};
    c = r[66:0];
    c[off + 1 -: 2] = hdr;
    return c;
  endfunction

  function automatic logic [193:0] mk_buf(input logic [66:0] c, input logic [5:0] cnt);
    logic [223:0] r;
    logic [193:0] b;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b = r[193:0];
    for (int i = 0; i < 67; i++) b[193 - int'(cnt) - i] = c[66 - i];
    return b;
  endfunction

  // One dv cycle. hdr is placed in this chunk and becomes the header of the
  // block emitted on the next dv; exp_blk says whether this dv emits a block.
  task automatic send(input logic [1:0] hdr, input logic err, input logic [6:0] off,
                      input logic [5:0] cnt, input logic exp_blk);
    logic [66:0]  c;
    logic [133:0] cat;
    exp_t         e;
    c = mk_chunk(hdr, cur_off);
    gbox_buffer  = mk_buf(c, cnt);
    gbox_cnt     = cnt;
    block_offset = off;
    buffer_dv    = 1'b1;
    if (exp_blk) begin
      cat = {prev_chunk, c};
      for (int i = 0; i < 64; i++) e.data[63 - i] = cat[cur_off + 66 - i];
      e.hdr = prev_hdr;
      e.err = prev_err;
      e.cyc = cyc + 2;
      q.push_back(e);
    end
    prev_chunk = c;
    prev_hdr   = hdr;
    prev_err   = err;
    @(posedge clk_i);
    #1;
    buffer_dv = 1'b0;
  endtask

  task automatic lock_seq(input int n, input logic [6:0] off);
    for (int i = 0; i < n; i++) send(good_hdr(), 1'b0, off, 6'd0, 1'b0);
  endtask

  task automatic do_reset();
    buffer_dv = 1'b0;
    rst_i = 1'b1;
    q.delete();
    #7;
    rst_i = 1'b0;
    prev_chunk = '0;
    prev_hdr   = 2'b01;
    prev_err   = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_blk_dv"},   64'(blk_dv_o), 64'd0);
    chk({tag, "_hdr_err"},  64'(blk_hdr_err_o), 64'd0);
    chk({tag, "_header"},   64'(blk_header_o), 64'd0);
    chk({tag, "_data"},     blk_data_o, 64'd0);
    chk({tag, "_locked"},   64'(locked_o), 64'd0);
    chk({tag, "_lock_off"}, 64'(lock_offset_o), 64'd0);
    chk({tag, "_loss_cnt"}, 64'(lock_loss_cnt_o), 64'd0);
  endtask

  // Window-end bad-header pattern: 15 bad per window for windows 0..3,
  // then 16 bad in window 4 with the 16th on its last block.
  function automatic logic blk_is_bad(input int j);
    int pos, win;
    pos = ((j - 1) % 64) + 1;
    win = (j - 1) / 64;
    if (win < 4) return pos >= 50;
    if (win == 4) return pos >= 49;
    return 1'b0;
  endfunction

  // Block monitor: every strobe must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && blk_dv_o) begin
      if (q.size() == 0) begin
        chk("unexpected_blk_dv", 64'(blk_dv_o), 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("blk_cycle",  64'(cyc), 64'(mon_e.cyc));
        chk("blk_header", 64'(blk_header_o), 64'(mon_e.hdr));
        chk("blk_data",   blk_data_o, mon_e.data);
        chk("blk_hdr_err", 64'(blk_hdr_err_o), 64'(mon_e.err));
      end
    end
  end

  initial begin
    tbl[0] = '{cnt: 6'd0,  hdr: 2'b01, err: 1'b0};
    tbl[1] = '{cnt: 6'd1,  hdr: 2'b10, err: 1'b0};
    tbl[2] = '{cnt: 6'd17, hdr: 2'b00, err: 1'b1};
    tbl[3] = '{cnt: 6'd63, hdr: 2'b11, err: 1'b1};
    tbl[4] = '{cnt: 6'd32, hdr: 2'b10, err: 1'b0};
    tbl[5] = '{cnt: 6'd5,  hdr: 2'b01, err: 1'b0};
    tbl[6] = '{cnt: 6'd40, hdr: 2'b00, err: 1'b1};
    tbl[7] = '{cnt: 6'd0,  hdr: 2'b10, err: 1'b0};

    // Reset state, then lock on 23 and run the vector table.
    #1 rst_i = 1'b1;
    #1 check_zero("reset");
    do_reset();
    cur_off = 23;
    lock_seq(15, 7'd23);
    chk("lock23_after15_locked", 64'(locked_o), 64'd0);
    lock_seq(1, 7'd23);
    chk("lock23_after16_locked", 64'(locked_o), 64'd1);
    chk("lock23_offset", 64'(lock_offset_o), 64'd23);
    for (int i = 0; i < 8; i++) send(tbl[i].hdr, tbl[i].err, 7'd23, tbl[i].cnt, 1'b1);
    send(2'b01, 1'b0, 7'd23, 6'd0, 1'b1);
    idle(4);
    chk("hold_blk_dv", 64'(blk_dv_o), 64'd0);
    chk("hold_header", 64'(blk_header_o), 64'(tbl[7].hdr));
    chk("tbl_all_blocks_seen", 64'(q.size()), 64'd0);

    // Candidate change in VERIFY restarts the count; lock on 40.
    do_reset();
    cur_off = 40;
    for (int i = 0; i < 10; i++) send(good_hdr(), 1'b0, 7'd23, 6'd0, 1'b0);
    send(good_hdr(), 1'b0, 7'd40, 6'd0, 1'b0);
    lock_seq(14, 7'd40);
    chk("verify40_15_locked", 64'(locked_o), 64'd0);
    chk("verify40_candidate", 64'(lock_offset_o), 64'd40);
    lock_seq(1, 7'd40);
    chk("verify40_16_locked", 64'(locked_o), 64'd1);
    chk("verify40_offset", 64'(lock_offset_o), 64'd40);

    // Windows 0..3 carry 15 bad headers each; the 16th bad of window 4
    // lands on its final block.
    for (int j = 1; j <= 320; j++) begin
      if (blk_is_bad(j + 1)) send((j % 2 == 0) ? 2'b00 : 2'b11, 1'b1, 7'd40, 6'd0, 1'b1);
      else send(good_hdr(), 1'b0, 7'd40, 6'd0, 1'b1);
      if (j == 256) chk("win4x15_locked", 64'(locked_o), 64'd1);
      if (j == 319) begin
        chk("win_pre_end_locked", 64'(locked_o), 64'd1);
        chk("win_pre_end_loss", 64'(lock_loss_cnt_o), 64'd0);
      end
    end
    chk("win_end_loss_locked", 64'(locked_o), 64'd0);
    chk("win_end_loss_cnt", 64'(lock_loss_cnt_o), 64'd1);
    send(good_hdr(), 1'b0, 7'd40, 6'd0, 1'b0);
    idle(3);
    chk("win_all_blocks_seen", 64'(q.size()), 64'd0);

    // Invalid offset in VERIFY drops back to HUNT.
    do_reset();
    cur_off = 23;
    lock_seq(5, 7'd23);
    send(good_hdr(), 1'b0, 7'd70, 6'd0, 1'b0);
    lock_seq(11, 7'd23);
    chk("invalid_off_locked", 64'(locked_o), 64'd0);
    idle(3);

    // 16 bad headers in one window lose lock.
    do_reset();
    cur_off = 23;
    lock_seq(16, 7'd23);
    for (int k = 1; k <= 16; k++) send((k % 2 == 0) ? 2'b11 : 2'b00, 1'b1, 7'd23, 6'd0, 1'b1);
    chk("bad15_locked", 64'(locked_o), 64'd1);
    chk("bad15_loss", 64'(lock_loss_cnt_o), 64'd0);
    send(good_hdr(), 1'b0, 7'd23, 6'd0, 1'b1);
    chk("bad16_locked", 64'(locked_o), 64'd0);
    chk("bad16_loss", 64'(lock_loss_cnt_o), 64'd1);
    send(good_hdr(), 1'b0, 7'd23, 6'd0, 1'b0);
    lock_seq(15, 7'd23);
    chk("relock_locked", 64'(locked_o), 64'd1);

    // Async reset mid-stream while locked.
    for (int k = 0; k < 4; k++) send(good_hdr(), 1'b0, 7'd23, 6'd0, 1'b1);
    chk("pre_rst_locked", 64'(locked_o), 64'd1);
    chk("pre_rst_loss", 64'(lock_loss_cnt_o), 64'd1);
    buffer_dv = 1'b1;
    #2;
    rst_i = 1'b1;
    q.delete();
    #1 check_zero("async_rst");
    #10;
    buffer_dv = 1'b0;
    rst_i = 1'b0;
    prev_chunk = '0;
    prev_hdr   = 2'b01;
    prev_err   = 1'b0;
    @(posedge clk_i);
    #1;
    lock_seq(15, 7'd23);
    chk("post_rst_15_locked", 64'(locked_o), 64'd0);
    lock_seq(1, 7'd23);
    chk("post_rst_16_locked", 64'(locked_o), 64'd1);
    send(good_hdr(), 1'b0, 7'd23, 6'd0, 1'b1);
    idle(3);
    chk("post_rst_blocks_seen", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
